obi_arbiter_2x1: RTL and testbench

OBI_ARBITER_2X1 -- requirements
Module: obi_arbiter_2x1

---
 rtl/obi_arbiter_2x1.sv | 157 +++++++++++++++
 tb/tb_obi_arbiter_2x1.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_arbiter_2x1.sv
// Two-master to one-slave OBI arbiter: round-robin selection with address-phase
// locking, and an in-order ID FIFO that steers each response back to its issuer.
module obi_arbiter_2x1 #(
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        s_req_o,
    input  logic        s_gnt_i,
    output logic [31:0] s_addr_o,
    output logic        s_we_o,
    output logic [3:0]  s_be_o,
    output logic [31:0] s_wdata_o,
    input  logic        s_rvalid_i,
    input  logic [31:0] s_rdata_i,
    output logic        err_o
);

    localparam int unsigned PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTST);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTST - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_e;

    state_e           state_q, state_d;
    logic             lock_id_q, lock_id_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             err_q, err_d;
    logic             id_mem_q [MAX_OUTST];

    logic sel;
    logic full;
    logic accept;
    logic pop;
    logic head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    // A stalled request keeps its master selected so the slave sees a stable address phase.
    always_comb begin
        if (state_q == ST_LOCKED) begin
            sel = lock_id_q;
        end else if (m0_req_i && m1_req_i) begin
            sel = prio_q;
        end else begin
            sel = m1_req_i;
        end
    end

    assign full    = (count_q == CNT_FULL);
    assign s_req_o = (m0_req_i | m1_req_i) & ~full & ~rst_i;
    assign accept  = s_req_o & s_gnt_i;

    assign m0_gnt_o = accept & ~sel;
    assign m1_gnt_o = accept & sel;

    assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign head        = id_mem_q[rd_ptr_q];
    assign pop         = s_rvalid_i & (count_q != '0);
    assign m0_rvalid_o = pop & ~head & ~rst_i;
    assign m1_rvalid_o = pop & head & ~rst_i;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign err_o       = err_q;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
        state_d   = state_q;
        lock_id_d = lock_id_q;
        prio_d    = prio_q;
        count_d   = count_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        err_d     = err_q;

        if (accept) begin
            state_d  = ST_IDLE;
            prio_d   = ~sel;
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else if (s_req_o) begin
            state_d   = ST_LOCKED;
            lock_id_d = sel;
        end

        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (s_rvalid_i && (count_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q   <= ST_IDLE;
            lock_id_q <= 1'b0;
            prio_q    <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            prio_q    <= prio_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            err_q     <= err_d;
        end
    end

    // NOTE: the ID storage has no reset; an entry is only read after count says it was written.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            id_mem_q[wr_ptr_q] <= sel;
        end
    end

endmodule

// File: tb/tb_obi_arbiter_2x1.sv
// Self-checking bench for obi_arbiter_2x1: directed scenarios plus random traffic,
// all compared against a queue-based transaction model.
module tb_obi_arbiter_2x1;

    localparam int MO = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_req_i = 1'b0, m1_req_i = 1'b0;
    logic        m0_gnt_o, m1_gnt_o;
    logic [31:0] m0_addr_i = '0, m1_addr_i = '0;
    logic        m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic [3:0]  m0_be_i = '0, m1_be_i = '0;
    logic [31:0] m0_wdata_i = '0, m1_wdata_i = '0;
    logic        m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o;
    logic        s_gnt_i = 1'b0;
    logic [31:0] s_addr_o;
    logic        s_we_o;
    logic [3:0]  s_be_o;
    logic [31:0] s_wdata_o;
    logic        s_rvalid_i = 1'b0;
    logic [31:0] s_rdata_i = '0;
    logic        err_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Transaction-level model: issuer queue, favoured master, pending-lock record, error flag.
    int q[$];
    int m_prio;
    bit m_locked;
    int m_lock_id;
    bit m_err;

    obi_arbiter_2x1 #(.MAX_OUTST(MO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
        .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
        .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .s_req_o(s_req_o), .s_gnt_i(s_gnt_i), .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_be_o(s_be_o),
        .s_wdata_o(s_wdata_o), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int model_sel();
        if (m_locked) return m_lock_id;
        if (m0_req_i && m1_req_i) return m_prio;
        return m1_req_i ? 1 : 0;
    endfunction

    // Bit order: gnt0, gnt1, s_req, rvalid0, rvalid1, err, addr, we, be, wdata, rdata0, rdata1.
    function automatic logic [138:0] model_out();
        int  n, sel, hd;
        bit  sreq, acc, rv0, rv1;
        n    = q.size();
        sel  = model_sel();
        sreq = (m0_req_i || m1_req_i) && (n != MO) && !rst_i;
        acc  = sreq && s_gnt_i;
        hd   = (n > 0) ? q[0] : -1;
        rv0  = s_rvalid_i && !rst_i && (hd == 0);
        rv1  = s_rvalid_i && !rst_i && (hd == 1);
        return {acc && (sel == 0), acc && (sel == 1), sreq, rv0, rv1, m_err,
                (sel == 1) ? m1_addr_i : m0_addr_i, (sel == 1) ? m1_we_i : m0_we_i,
                (sel == 1) ? m1_be_i : m0_be_i, (sel == 1) ? m1_wdata_i : m0_wdata_i,
                s_rdata_i, s_rdata_i};
    endfunction

    function automatic logic [138:0] dut_vec();
        return {m0_gnt_o, m1_gnt_o, s_req_o, m0_rvalid_o, m1_rvalid_o, err_o, s_addr_o, s_we_o,
                s_be_o, s_wdata_o, m0_rdata_o, m1_rdata_o};
    endfunction

    task automatic model_reset();
        q.delete();
        m_prio    = 0;
        m_locked  = 1'b0;
        m_lock_id = 0;
        m_err     = 1'b0;
    endtask

    task automatic model_step();
        int  n, sel;
        bit  sreq;
        if (rst_i) begin
            model_reset();
            return;
        end
        n    = q.size();
        sel  = model_sel();
        sreq = (m0_req_i || m1_req_i) && (n != MO);
        if (s_rvalid_i) begin
            if (n > 0) void'(q.pop_front());
            else m_err = 1'b1;
        end
        if (sreq && s_gnt_i) begin
            q.push_back(sel);
            m_prio   = 1 - sel;
            m_locked = 1'b0;
        end else if (sreq) begin
            m_locked  = 1'b1;
            m_lock_id = sel;
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    task automatic set_in(input bit r0, input bit r1, input bit g, input bit rv);
        m0_req_i   = r0;
        m1_req_i   = r1;
        s_gnt_i    = g;
        s_rvalid_i = rv;
        s_rdata_i  = $urandom;
    endtask

    task automatic rand_payload();
        m0_addr_i  = $urandom;
        m1_addr_i  = ~m0_addr_i;
        m0_we_i    = 1'($urandom);
        m1_we_i    = ~m0_we_i;
        m0_be_i    = 4'($urandom);
        m1_be_i    = ~m0_be_i;
        m0_wdata_i = $urandom;
        m1_wdata_i = $urandom;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        model_reset();
        set_in(0, 0, 0, 0);
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [138:0] exp;
        model_reset();
        rand_payload();
        set_in(1, 1, 1, 1);
        @(negedge clk_i);
        exp = model_out();
        n_checks++;
        if (dut_vec() !== exp) begin
            n_fail++;
            $display("FAIL reset_model: got %h want %h", dut_vec(), exp);
        end
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, s_req_o, m0_rvalid_o, m1_rvalid_o, err_o} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 000000",
                     {m0_gnt_o, m1_gnt_o, s_req_o, m0_rvalid_o, m1_rvalid_o, err_o});
        end
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [138:0] exp;
        logic [1:0]   want;
        do_reset();
        for (int k = 0; k < 8; k++) begin
            rand_payload();
            set_in(1, 1, 1, k > 0);
            @(negedge clk_i);
            exp = model_out();
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("FAIL rr_model cycle %0d: got %h want %h", k, dut_vec(), exp);
            end
            want = (k % 2 == 0) ? 2'b10 : 2'b01;
            n_checks++;
            if ({m0_gnt_o, m1_gnt_o} !== want) begin
                n_fail++;
                $display("FAIL rr_grant cycle %0d: got %b want %b", k, {m0_gnt_o, m1_gnt_o}, want);
            end
            if (k > 0) begin
                want = ((k - 1) % 2 == 0) ? 2'b10 : 2'b01;
                n_checks++;
                if ({m0_rvalid_o, m1_rvalid_o} !== want) begin
                    n_fail++;
                    $display("FAIL rr_rvalid cycle %0d: got %b want %b", k,
                             {m0_rvalid_o, m1_rvalid_o}, want);
                end
            end
            tick();
        end
        set_in(0, 0, 0, 1);
        @(negedge clk_i);
        n_checks++;
        if ({m0_rvalid_o, m1_rvalid_o} !== 2'b01) begin
            n_fail++;
            $display("FAIL rr_drain: got %b want 01", {m0_rvalid_o, m1_rvalid_o});
        end
        tick();
    endtask

    task automatic test_lock();
        logic [138:0] exp;
        // {req0, req1, gnt, rvalid, expected {gnt0,gnt1}, expected {rv0,rv1}}
        logic [7:0] tbl [8];
        tbl[0] = {4'b1010, 2'b10, 2'b00};
        tbl[1] = {4'b1001, 2'b00, 2'b10};
        tbl[2] = {4'b1100, 2'b00, 2'b00};
        tbl[3] = {4'b1100, 2'b00, 2'b00};
        tbl[4] = {4'b1110, 2'b10, 2'b00};
        tbl[5] = {4'b0110, 2'b01, 2'b00};
        tbl[6] = {4'b0001, 2'b00, 2'b10};
        tbl[7] = {4'b0001, 2'b00, 2'b01};
        do_reset();
        rand_payload();
        for (int k = 0; k < 8; k++) begin
            set_in(tbl[k][7], tbl[k][6], tbl[k][5], tbl[k][4]);
            @(negedge clk_i);
            exp = model_out();
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("FAIL lock_model step %0d: got %h want %h", k, dut_vec(), exp);
            end
            n_checks++;
            if ({m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o} !== tbl[k][3:0]) begin
                n_fail++;
                $display("FAIL lock_handshake step %0d: got %b want %b", k,
                         {m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o}, tbl[k][3:0]);
            end
            if (k >= 1 && k <= 4) begin
                n_checks++;
                if (s_addr_o !== m0_addr_i) begin
                    n_fail++;
                    $display("FAIL lock_addr step %0d: got %h want %h", k, s_addr_o, m0_addr_i);
                end
            end
            tick();
        end
    endtask

    task automatic test_full();
        logic [138:0] exp;
        // {req0, rvalid, expected s_req, expected gnt0, expected rv0}
        logic [4:0] tbl [6];
        tbl[0] = 5'b10110;
        tbl[1] = 5'b10110;
        tbl[2] = 5'b11001;
        tbl[3] = 5'b10110;
        tbl[4] = 5'b01001;
        tbl[5] = 5'b01001;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            rand_payload();
            set_in(tbl[k][4], 0, 1, tbl[k][3]);
            @(negedge clk_i);
            exp = model_out();
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("FAIL full_model step %0d: got %h want %h", k, dut_vec(), exp);
            end
            n_checks++;
            if ({s_req_o, m0_gnt_o, m0_rvalid_o} !== tbl[k][2:0]) begin
                n_fail++;
                $display("FAIL full_flow step %0d: got %b want %b", k,
                         {s_req_o, m0_gnt_o, m0_rvalid_o}, tbl[k][2:0]);
            end
            tick();
        end
    endtask

    task automatic test_spurious();
        do_reset();
        set_in(0, 0, 0, 1);
        @(negedge clk_i);
        n_checks++;
        if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL spurious_route: got %b want 000", {m0_rvalid_o, m1_rvalid_o, err_o});
        end
        tick();
        set_in(0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            n_checks++;
            if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b001 || err_o !== m_err) begin
                n_fail++;
                $display("FAIL spurious_sticky cycle %0d: got %b want 001", k,
                         {m0_rvalid_o, m1_rvalid_o, err_o});
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        rand_payload();
        set_in(1, 0, 1, 0);
        @(negedge clk_i);
        n_checks++;
        if (m0_gnt_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_first_grant: got %b want 1", m0_gnt_o);
        end
        tick();
        set_in(0, 1, 1, 0);
        #2;
        rst_i = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, s_req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_grants: got %b want 000", {m0_gnt_o, m1_gnt_o, s_req_o});
        end
        tick();
        rst_i = 1'b0;
        set_in(0, 0, 0, 1);
        @(negedge clk_i);
        n_checks++;
        if ({m0_rvalid_o, m1_rvalid_o, err_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_count_zero: got %b want 000", {m0_rvalid_o, m1_rvalid_o, err_o});
        end
        tick();
        set_in(1, 1, 1, 0);
        @(negedge clk_i);
        n_checks++;
        if ({m0_gnt_o, m1_gnt_o, err_o} !== 3'b101) begin
            n_fail++;
            $display("FAIL midrst_prio_m0: got %b want 101", {m0_gnt_o, m1_gnt_o, err_o});
        end
        tick();
    endtask

    task automatic test_random();
        logic [138:0] exp;
        bit g0 = 1'b0, g1 = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!(m0_req_i && !g0)) begin
                m0_req_i   = ($urandom % 3) != 0;
                m0_addr_i  = $urandom;
                m0_we_i    = 1'($urandom);
                m0_be_i    = 4'($urandom);
                m0_wdata_i = $urandom;
            end
            if (!(m1_req_i && !g1)) begin
                m1_req_i   = ($urandom % 3) != 0;
                m1_addr_i  = $urandom;
                m1_we_i    = 1'($urandom);
                m1_be_i    = 4'($urandom);
                m1_wdata_i = $urandom;
            end
            s_gnt_i    = ($urandom % 4) != 0;
            s_rvalid_i = (q.size() > 0) ? (($urandom % 2) == 1) : (($urandom % 40) == 0);
            s_rdata_i  = $urandom;
            @(negedge clk_i);
            exp = model_out();
            g0  = exp[138];
            g1  = exp[137];
            n_checks++;
            if (dut_vec() !== exp) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h want %h", k, dut_vec(), exp);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_lock();
        test_full();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
